// File: rtl/demux_chan_counter_pkg.sv
`timescale 1ns/1ps
// Shared constants and read-FSM encoding for the per-channel demux event counter.
package demux_cnt_pkg;

  localparam int N_CHAN = 4;
  localparam int SEL_W  = 2;

  // The unused code 2'd3 is decoded as IDLE by the FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    VALID = 2'd2
  } rd_state_t;

endpackage

// File: rtl/chan_counter.sv
`timescale 1ns/1ps
// One channel: rising-edge detector, saturating event counter and sticky overflow flag.
module chan_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             clr,
  input  logic             rd_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic prev;
  logic edge_det;

  assign edge_det = in & ~prev;

  // NOTE: non-blocking assignments make every flop see pre-edge values, so prev/cnt ordering is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      prev <= in;
      if (clr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (rd_clr) begin
        // An edge coinciding with the read-clear restarts the count at 1 so it is not lost.
        cnt <= edge_det ? CNT_ONE : '0;
        ovf <= 1'b0;
      end else if (edge_det) begin
        if (cnt == CNT_MAX) begin
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/demux_chan_counter.sv
`timescale 1ns/1ps
// Four-channel rising-edge counter behind demux1_4 with a req/ack read-to-clear port.
module demux_chan_counter
  import demux_cnt_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              d,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_ack,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_ovf,
  output logic [N_CHAN-1:0] ovf
);

  logic [N_CHAN-1:0] chan_in;
  logic [N_CHAN-1:0] rd_clr;
  logic [CNT_W-1:0]  cnt [N_CHAN];

  rd_state_t         state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              load;

  assign chan_in = {d, c, b, a};

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    assign rd_clr[i] = load && (sel_q == SEL_W'(i));

    chan_counter #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .in     (chan_in[i]),
      .clr    (clr),
      .rd_clr (rd_clr[i]),
      .cnt    (cnt[i]),
      .ovf    (ovf[i])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    load    = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        LATCH: begin
          load    = 1'b1;
          state_d = VALID;
        end
        VALID: begin
          if (rd_ack) state_d = IDLE;
        end
        default: begin
          if (rd_req) begin
            state_d = LATCH;
            sel_d   = rd_sel;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      // Snapshot survives clr; only the valid indication is withdrawn.
      if (load) begin
        rd_data <= cnt[sel_q];
        rd_ovf  <= ovf[sel_q];
      end
    end
  end

  assign rd_valid = (state_q == VALID);

endmodule
